alu_bist_ctrl: RTL and testbench

//  Built-in self-test driver for the registered 8-bit ALU. Acts as the opposite end of the
//  ALU's interface: it generates pseudo-random instruction/operand patterns,

---
 rtl/alu_bist_ctrl_if.sv | 25 ++
 rtl/alu_bist_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_bist_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_bist_ctrl_if.sv
// ALU-side bus between the BIST driver and the 8-bit registered ALU under test.
// Latency: none (wires only); the ALU itself adds ALU_LATENCY edges.
// Backpressure: none; the ALU accepts one instruction per clock unconditionally.
interface alu_bist_ctrl_if;
  logic [3:0] instruction;
  logic [7:0] inputA;
  logic [7:0] inputB;
  logic [7:0] alu_out;

  // BIST driver side: drives the ALU inputs and observes its result
  modport master (
    output instruction,
    output inputA,
    output inputB,
    input  alu_out
  );

  // ALU side
  modport slave (
    input  instruction,
    input  inputA,
    input  inputB,
    output alu_out
  );
endinterface

// File: rtl/alu_bist_ctrl.sv
// BIST driver for the 8-bit ALU: LFSR patterns out, MISR-compacted results in, golden compare.
// Latency: pattern 0 after the start edge; done after start edge + NUM_PATTERNS + ALU_LATENCY.
// Backpressure: none; one pattern per clock, start ignored while busy.
// Optional feature macro ALU_BIST_SEED_EN adds a run-time seed_in port replacing SEED.
module alu_bist_ctrl #(
  parameter int unsigned NUM_PATTERNS = 16,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000,
  parameter int unsigned ALU_LATENCY  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
`ifdef ALU_BIST_SEED_EN
  input  logic [15:0]            seed_in,
`endif
  alu_bist_ctrl_if.master        alu,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            signature
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_PATTERNS);
  localparam logic [15:0] CAP_LAST = 16'(NUM_PATTERNS - 1);

  state_t               state_q;
  logic [15:0]          lfsr_q;     // state for the NEXT pattern to be driven
  logic [15:0]          idx_q;      // index of the next pattern to be driven
  logic [15:0]          cap_cnt_q;  // captures absorbed so far in this run
  logic [15:0]          misr_q;
  logic [ALU_LATENCY:0] vld_q;      // one bit per in-flight pattern
  logic [3:0]           ins_q;
  logic [7:0]           a_q;
  logic [7:0]           b_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;

  logic [15:0]          seed_raw;
  logic [15:0]          seed_d;
  logic [15:0]          lfsr_d;
  logic [15:0]          misr_d;
  logic                 capture;
  logic                 last_cap;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // seed selection with lock-up guard, next LFSR/MISR values, capture strobe
  always_comb begin
`ifdef ALU_BIST_SEED_EN
    seed_raw = seed_in;
`else
    seed_raw = SEED;
`endif
    seed_d   = (seed_raw == 16'h0000) ? 16'h0001 : seed_raw;
    lfsr_d   = lfsr_step(lfsr_q);
    misr_d   = lfsr_step(misr_q) ^ {8'h00, alu.alu_out};
    capture  = vld_q[ALU_LATENCY];
    last_cap = capture && (cap_cnt_q == CAP_LAST);
  end

  // run FSM: pattern generation, valid tracking, MISR compaction and verdict
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= '0;
      idx_q     <= '0;
      cap_cnt_q <= '0;
      misr_q    <= '0;
      vld_q     <= '0;
      ins_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      for (int j = ALU_LATENCY; j > 0; j--) vld_q[j] <= vld_q[j-1];
      vld_q[0] <= 1'b0;

      if (capture) begin
        misr_q    <= misr_d;
        cap_cnt_q <= cap_cnt_q + 16'd1;
      end

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= RUN;
            a_q       <= seed_d[7:0];
            b_q       <= seed_d[15:8];
            ins_q     <= 4'd0;
            lfsr_q    <= lfsr_step(seed_d);
            idx_q     <= 16'd1;
            cap_cnt_q <= '0;
            misr_q    <= '0;
            vld_q[0]  <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        RUN: begin
          if (idx_q == LAST_IDX) begin
            a_q     <= '0;
            b_q     <= '0;
            ins_q   <= '0;
            state_q <= DRAIN;
          end else begin
            a_q      <= lfsr_q[7:0];
            b_q      <= lfsr_q[15:8];
            ins_q    <= idx_q[3:0];
            lfsr_q   <= lfsr_d;
            idx_q    <= idx_q + 16'd1;
            vld_q[0] <= 1'b1;
          end
        end
        default: ;
      endcase

      // the final capture closes the run regardless of how RUN/DRAIN overlap
      if (last_cap && (state_q == RUN || state_q == DRAIN)) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        pass_q  <= (misr_d == GOLDEN_SIG);
      end
    end
  end

  assign alu.instruction = ins_q;
  assign alu.inputA      = a_q;
  assign alu.inputB      = b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign signature       = misr_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: four instances (N=16, N=4, two N=1 with different golden values).
// Latency: checks pattern timing and done edge exactly against hand-computed values.
// Backpressure: n/a; start pulses during a run are checked to be ignored.
module tb_alu_bist_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        st16, st4, st1;
  logic [15:0] seed_v;
  logic [7:0]  alu_small;
  logic        busy16, done16, pass16;
  logic        busy4, done4, pass4;
  logic        busy1a, done1a, pass1a;
  logic        busy1b, done1b, pass1b;
  logic [15:0] sig16, sig4, sig1a, sig1b;
  logic [7:0]  alu16_s1, alu16_q;
  int          n_chk = 0;
  int          n_bad = 0;

  alu_bist_ctrl_if if16();
  alu_bist_ctrl_if if4();
  alu_bist_ctrl_if if1a();
  alu_bist_ctrl_if if1b();

  function automatic logic [7:0] f_alu(input logic [3:0] ins, input logic [7:0] a, input logic [7:0] b);
    return a ^ (b + {4'h0, ins});
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // two-stage registered ALU model for the N=16 instance
  always @(posedge clk) begin
    alu16_s1 <= f_alu(if16.instruction, if16.inputA, if16.inputB);
    alu16_q  <= alu16_s1;
  end

  assign if16.alu_out = alu16_q;
  assign if4.alu_out  = 8'h00;
  assign if1a.alu_out = alu_small;
  assign if1b.alu_out = alu_small;

  alu_bist_ctrl #(.NUM_PATTERNS(16), .SEED(16'hACE1), .GOLDEN_SIG(16'h0000), .ALU_LATENCY(2)) u16 (
    .clk(clk), .reset(reset), .start(st16),
`ifdef ALU_BIST_SEED_EN
    .seed_in(seed_v),
`endif
    .alu(if16), .busy(busy16), .done(done16), .pass(pass16), .signature(sig16));

  alu_bist_ctrl #(.NUM_PATTERNS(4), .SEED(16'hACE1), .GOLDEN_SIG(16'h0000), .ALU_LATENCY(2)) u4 (
    .clk(clk), .reset(reset), .start(st4),
`ifdef ALU_BIST_SEED_EN
    .seed_in(seed_v),
`endif
    .alu(if4), .busy(busy4), .done(done4), .pass(pass4), .signature(sig4));

  alu_bist_ctrl #(.NUM_PATTERNS(1), .SEED(16'hACE1), .GOLDEN_SIG(16'h0001), .ALU_LATENCY(2)) u1a (
    .clk(clk), .reset(reset), .start(st1),
`ifdef ALU_BIST_SEED_EN
    .seed_in(seed_v),
`endif
    .alu(if1a), .busy(busy1a), .done(done1a), .pass(pass1a), .signature(sig1a));

  alu_bist_ctrl #(.NUM_PATTERNS(1), .SEED(16'hACE1), .GOLDEN_SIG(16'h0002), .ALU_LATENCY(2)) u1b (
    .clk(clk), .reset(reset), .start(st1),
`ifdef ALU_BIST_SEED_EN
    .seed_in(seed_v),
`endif
    .alu(if1b), .busy(busy1b), .done(done1b), .pass(pass1b), .signature(sig1b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] s;
    logic [15:0] m;
    logic [7:0]  ea, eb;
    logic [3:0]  ei;

    reset = 1'b1; st16 = 1'b0; st4 = 1'b0; st1 = 1'b0;
    seed_v = 16'hACE1; alu_small = 8'h00;
    repeat (3) tick;
    chk("rst16", {busy16, done16, pass16, sig16, if16.instruction, if16.inputA, if16.inputB}, 32'h0);
    chk("rst4",  {busy4, done4, pass4, sig4, if4.instruction, if4.inputA, if4.inputB}, 32'h0);
    reset = 1'b0;
    tick;
    chk("idle16", {busy16, done16, pass16}, 32'h0);

    // full N=16 run with start pulses in RUN (c=2) and DRAIN (c=17) that must be ignored
    st16 = 1'b1;
    tick;
    st16 = 1'b0;
    s = 16'hACE1;
    m = 16'h0000;
    for (int c = 0; c <= 18; c++) begin
      if (c < 16) begin
        ea = s[7:0]; eb = s[15:8]; ei = 4'(c);
        m  = lfsr_step(m) ^ {8'h00, f_alu(ei, ea, eb)};
        s  = lfsr_step(s);
      end else begin
        ea = 8'h00; eb = 8'h00; ei = 4'h0;
      end
      if (c == 0) chk("t1_p0", {if16.instruction, if16.inputA, if16.inputB}, {4'h0, 8'hE1, 8'hAC});
      if (c == 1) chk("t1_p1", {if16.instruction, if16.inputA, if16.inputB}, {4'h1, 8'hC3, 8'h59});
      chk($sformatf("pat_c%0d", c), {if16.instruction, if16.inputA, if16.inputB}, {ei, ea, eb});
      chk($sformatf("busy_c%0d", c), busy16, (c < 18) ? 1'b1 : 1'b0);
      chk($sformatf("done_c%0d", c), done16, (c == 18) ? 1'b1 : 1'b0);
      st16 = (c == 2 || c == 17) ? 1'b1 : 1'b0;
      if (c < 18) tick;
    end
    st16 = 1'b0;
    chk("sig16", sig16, m);
    chk("pass16", pass16, (m == GOLDEN16()) ? 1'b1 : 1'b0);
    repeat (2) tick;
    chk("sig16_hold", {done16, sig16}, {1'b1, m});

    // start in DONE begins a new run, then reset at k+2 aborts it
    st16 = 1'b1;
    tick;
    st16 = 1'b0;
    chk("redo_p0", {done16, busy16, if16.instruction, if16.inputA, if16.inputB}, {1'b0, 1'b1, 4'h0, 8'hE1, 8'hAC});
    tick;
    chk("redo_p1", {if16.instruction, if16.inputA, if16.inputB}, {4'h1, 8'hC3, 8'h59});
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort16", {busy16, done16, pass16, sig16, if16.instruction, if16.inputA, if16.inputB}, 32'h0);
    tick;
    chk("abort_idle", {busy16, done16}, 32'h0);
    st16 = 1'b1;
    tick;
    st16 = 1'b0;
    chk("rerun_p0", {if16.instruction, if16.inputA, if16.inputB}, {4'h0, 8'hE1, 8'hAC});
    tick;
    chk("rerun_p1", {if16.instruction, if16.inputA, if16.inputB}, {4'h1, 8'hC3, 8'h59});
    for (int i = 0; i < 40 && !done16; i++) tick;
    chk("rerun_done", {done16, sig16}, {1'b1, m});

    // N=4 with an all-zero ALU: done exactly after k+6
    st4 = 1'b1;
    tick;
    st4 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c == 5) chk("n4_c5", {busy4, done4}, {1'b1, 1'b0});
    end
    chk("n4_c6", {busy4, done4, pass4, sig4}, {1'b0, 1'b1, 1'b1, 16'h0000});

    // N=1: alu_out=01 only on the capture edge k+3
    st1 = 1'b1;
    tick;
    st1 = 1'b0;
    tick;
    tick;
    chk("n1_k2", {done1a, busy1a}, {1'b0, 1'b1});
    alu_small = 8'h01;
    tick;
    alu_small = 8'h00;
    chk("n1a_res", {done1a, pass1a, sig1a}, {1'b1, 1'b1, 16'h0001});
    chk("n1b_res", {done1b, pass1b, sig1b}, {1'b1, 1'b0, 16'h0001});
    tick;
    chk("n1a_hold", {done1a, sig1a}, {1'b1, 16'h0001});

`ifdef ALU_BIST_SEED_EN
    seed_v = 16'h0000;
    st4 = 1'b1;
    tick;
    st4 = 1'b0;
    chk("seed0", {if4.inputA, if4.inputB}, {8'h01, 8'h00});
    for (int i = 0; i < 20 && !done4; i++) tick;
    chk("seed0_done", done4, 1'b1);
    seed_v = 16'h1234;
    st4 = 1'b1;
    tick;
    st4 = 1'b0;
    chk("seed1234", {if4.inputA, if4.inputB}, {8'h34, 8'h12});
    seed_v = 16'hACE1;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  function automatic logic [15:0] GOLDEN16();
    return 16'h0000;
  endfunction

endmodule
